l2_array_pipe: RTL and testbench
================================

# l2_array_pipe

Parametrised, pipelined successor to the CPU64 L2 tag/data array. It holds SETS×WAYS lines of WORDS data words plus per-way tag, valid and dirty state behind a single valid/ready request port, with registered responses. It adds a post-reset valid/dirty clear sweep, an associative tag LOOKUP, and a multi-cycle LINE_READ burst for eviction. It sits between the L2 controller FSM and the refill/writeback datapath.

## Interface
- SETS, 256: number of sets; power of two. INDEX_W = clog2(SETS).
- WAYS, 16: associativity; power of two. WAY_W = clog2(WAYS).
- WORDS, 8: words per line; power of two. WORD_W = clog2(WORDS).
- DATA_W, 64: word width; multiple of 8. BE_W = DATA_W/8.
- TAG_W, 50: tag width.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&ready
- req_op_i  in  2  0 READ, 1 WRITE, 2 LOOKUP, 3 LINE_READ
- req_index_i  in  INDEX_W  set
- req_way_i  in  WAY_W  way (ignored by LOOKUP)
- req_word_i  in  WORD_W  word select (ignored by LINE_READ)
- req_be_i  in  BE_W  byte enables for WRITE data
- req_wdata_i  in  DATA_W  write data
- req_tag_i  in  TAG_W  tag to write (WRITE) or compare (LOOKUP)
- req_meta_we_i  in  1  WRITE also updates tag/valid/dirty
- req_valid_bit_i, req_dirty_bit_i  in  1 each  metadata values for WRITE
- rsp_valid_o  out  1  response beat valid
- rsp_data_o  out  DATA_W  word
- rsp_tag_o  out  TAG_W  tag of addressed/hit way
- rsp_vld_o, rsp_dirty_o  out  1 each  valid/dirty of that way
- rsp_hit_o, rsp_multi_hit_o  out  1 each  LOOKUP results
- rsp_way_o  out  WAY_W  hit way (LOOKUP) or requested way
- rsp_last_o  out  1  final beat of a response
- init_done_o  out  1  sweep complete

## Operation
- FSM states INIT, IDLE, BURST. The package enum encodes them.
- INIT, entered on reset: a set counter runs 0..SETS-1 and clears valid and dirty of all ways, one set per cycle. Data and tag contents are undefined and not cleared. After SETS cycles the FSM moves to IDLE and init_done_o goes to 1 and stays there.
- IDLE: req_ready_o = 1. Any op is accepted.
- READ: returns word, tag, valid and dirty of (index, way, word). rsp_hit_o = 0.
- WRITE: merges req_wdata_i into the word per byte enable. If meta_we is set, tag, valid and dirty are overwritten. WRITE also produces one response beat carrying the post-write contents.
- LOOKUP: compares req_tag_i against all ways whose valid bit is set.
  - hit: rsp_way_o is the lowest matching way; data is word req_word_i of that way.
  - multi_hit: set when two or more ways match.
  - miss: data, tag and way are 0.
- LINE_READ: the FSM goes to BURST. Beats for words 0..WORDS-1 of (index, way) come out on consecutive cycles. rsp_last_o is set on word WORDS-1. req_ready_o = 0 throughout BURST. The FSM returns to IDLE on the cycle after the last beat.
- Single-beat ops assert rsp_last_o = 1.
- The response has no backpressure; the consumer must accept every beat.

## Timing
- Reset values: req_ready_o 0, init_done_o 0, rsp_valid_o 0, all rsp_* fields 0, FSM in INIT.
- Single-beat latency: accept on edge N gives rsp_valid_o high for exactly the cycle after edge N+1. Back-to-back requests give one response per cycle.
- Read-after-write: a request accepted the cycle after a WRITE to the same location sees the written data and metadata.
- LINE_READ: accept on edge N gives beats in cycles N+1..N+WORDS. req_ready_o rises again in the cycle after the last beat.
- Reset asserted mid-burst or mid-sweep: the FSM returns to INIT immediately, outputs return to reset values, and the sweep restarts from set 0.
- Requests presented while ready = 0 are not accepted. They must be held stable.
- be = 0 on WRITE leaves data unchanged. Metadata still updates if meta_we is set.

## Structure
- The shared package l2_arrays_pkg holds:
  - op encoding enum
  - FSM state enum
  - the WAY_W/INDEX_W/WORD_W derivation functions
- Sub-module l2_tag_match (combinational): takes the valid vector and the flat tag vector, and produces hit, multi_hit and a lowest-index priority-encoded way.
- Arrays are inferred memories with registered read:
  - data: SETS·WAYS·WORDS × DATA_W
  - tag: SETS·WAYS × TAG_W
  - valid and dirty: flops, for single-cycle sweep and LOOKUP.

## Test plan
- Reset sweep: release reset → req_ready_o = 0 for 256 cycles, then init_done_o = 1. LOOKUP of any tag at any index → rsp_hit_o = 0.
- WRITE index 0x10, way 5, word 2, be 0xFF, data 0xDEADBEEFCAFEBABE, tag 0x123456789ABC, meta_we, valid 1 → next-cycle READ returns the same data/tag with rsp_vld_o = 1. Then WRITE be 0x0F, data 0x11111111 → READ returns 0xDEADBEEF11111111.
- LOOKUP tag 0x123456789ABC at index 0x10 → hit = 1, way = 5, multi_hit = 0. Add the same tag valid in way 9 → way = 5, multi_hit = 1. Other index → hit = 0.
- LINE_READ index 0x20, way 3, with word i preloaded to 0x100+i → 8 consecutive beats 0x100..0x107, last only on beat 8, ready = 0 for those 8 cycles.
- Back-to-back READ/WRITE/READ of the same word on consecutive cycles → three consecutive response beats, the third showing the written value.
- Assert rst_n low during beat 4 of a LINE_READ → rsp_valid_o goes low immediately, the sweep restarts, and the earlier valid bits read 0 after init.

Source files
------------

// File: rtl/l2_arrays_pkg.sv
// Shared types and width helpers for the pipelined L2 tag/data array.
package l2_arrays_pkg;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_LOOKUP    = 2'd2,
    OP_LINE_READ = 2'd3
  } l2_op_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2
  } l2_state_e;

  // Degenerate sizes of 1 still need a one-bit field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int index_w(input int sets);
    return clog2_min1(sets);
  endfunction

  function automatic int way_w(input int ways);
    return clog2_min1(ways);
  endfunction

  function automatic int word_w(input int words);
    return clog2_min1(words);
  endfunction

endpackage

// File: rtl/l2_tag_match.sv
// Associative tag compare across all ways of one set, lowest matching way wins.
module l2_tag_match
  import l2_arrays_pkg::*;
#(
  parameter int  WAYS  = 16,
  parameter int  TAG_W = 50,
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic [WAYS-1:0]       valid_i,
  input  logic [WAYS*TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  hit_o,
  output logic                  multi_hit_o,
  output logic [WAY_W-1:0]      way_o
);

  logic [WAYS-1:0] match;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
    assign match[gi] = valid_i[gi] && (tags_i[gi*TAG_W +: TAG_W] == tag_i);
  end

  always_comb begin
    hit_o       = |match;
    // Clearing the lowest set bit leaves something only if two or more ways matched.
    multi_hit_o = |(match & (match - WAYS'(1)));
    way_o       = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) way_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/l2_array_pipe.sv
// Pipelined L2 tag/data array: valid/ready request port, registered responses,
// post-reset valid/dirty sweep, associative LOOKUP and LINE_READ burst.
module l2_array_pipe
  import l2_arrays_pkg::*;
#(
  parameter int  SETS    = 256,
  parameter int  WAYS    = 16,
  parameter int  WORDS   = 8,
  parameter int  DATA_W  = 64,
  parameter int  TAG_W   = 50,
  localparam int INDEX_W = index_w(SETS),
  localparam int WAY_W   = way_w(WAYS),
  localparam int WORD_W  = word_w(WORDS),
  localparam int BE_W    = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_op_i,
  input  logic [INDEX_W-1:0] req_index_i,
  input  logic [WAY_W-1:0]   req_way_i,
  input  logic [WORD_W-1:0]  req_word_i,
  input  logic [BE_W-1:0]    req_be_i,
  input  logic [DATA_W-1:0]  req_wdata_i,
  input  logic [TAG_W-1:0]   req_tag_i,
  input  logic               req_meta_we_i,
  input  logic               req_valid_bit_i,
  input  logic               req_dirty_bit_i,
  output logic               rsp_valid_o,
  output logic [DATA_W-1:0]  rsp_data_o,
  output logic [TAG_W-1:0]   rsp_tag_o,
  output logic               rsp_vld_o,
  output logic               rsp_dirty_o,
  output logic               rsp_hit_o,
  output logic               rsp_multi_hit_o,
  output logic [WAY_W-1:0]   rsp_way_o,
  output logic               rsp_last_o,
  output logic               init_done_o
);

  localparam logic [INDEX_W-1:0] LAST_SET  = INDEX_W'(SETS - 1);
  localparam logic [WORD_W-1:0]  LAST_WORD = WORD_W'(WORDS - 1);
  localparam logic [WORD_W:0]    BURST_END = (WORD_W + 1)'(WORDS);

  l2_op_e req_op;
  assign req_op = l2_op_e'(req_op_i);

  l2_state_e          state_q, state_d;
  logic [INDEX_W-1:0] init_cnt_q, init_cnt_d;
  logic [WORD_W:0]    burst_cnt_q, burst_cnt_d;
  logic [INDEX_W-1:0] burst_index_q, burst_index_d;
  logic [WAY_W-1:0]   burst_way_q, burst_way_d;

  // Stage 1: request attributes travelling alongside the registered array read.
  logic               s1_valid_q, s1_valid_d;
  l2_op_e             s1_op_q, s1_op_d;
  logic [WAY_W-1:0]   s1_way_q, s1_way_d;
  logic [BE_W-1:0]    s1_be_q, s1_be_d;
  logic [DATA_W-1:0]  s1_wdata_q, s1_wdata_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s1_meta_q, s1_meta_d;
  logic               s1_vbit_q, s1_vbit_d;
  logic               s1_dbit_q, s1_dbit_d;
  logic [WAYS-1:0]    s1_vvec_q, s1_vvec_d;
  logic [WAYS-1:0]    s1_dvec_q, s1_dvec_d;
  logic               s1_last_q, s1_last_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_vld_q, rsp_vld_d;
  logic               rsp_dirty_q, rsp_dirty_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               rsp_multi_q, rsp_multi_d;
  logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;
  logic               rsp_last_q, rsp_last_d;

  logic [WAYS-1:0]    valid_mem [SETS];
  logic [WAYS-1:0]    dirty_mem [SETS];

  logic               accept, data_we, meta_we;
  logic [INDEX_W-1:0] rd_index;
  logic [WORD_W-1:0]  rd_word;
  logic [WAYS*DATA_W-1:0] rd_data_flat;
  logic [WAYS*TAG_W-1:0]  rd_tag_flat;

  always_comb begin
    accept     = (state_q == ST_IDLE) && req_valid_i;
    data_we    = accept && (req_op == OP_WRITE);
    meta_we    = data_we && req_meta_we_i;
    rd_index   = req_index_i;
    rd_word    = (req_op == OP_LINE_READ) ? '0 : req_word_i;
    s1_valid_d = accept;
    s1_op_d    = req_op;
    s1_way_d   = req_way_i;
    s1_be_d    = req_be_i;
    s1_wdata_d = req_wdata_i;
    s1_tag_d   = req_tag_i;
    s1_meta_d  = req_meta_we_i;
    s1_vbit_d  = req_valid_bit_i;
    s1_dbit_d  = req_dirty_bit_i;
    s1_last_d  = (req_op != OP_LINE_READ) || (WORDS == 1);
    if (state_q == ST_BURST) begin
      rd_index   = burst_index_q;
      rd_word    = burst_cnt_q[WORD_W-1:0];
      s1_valid_d = burst_cnt_q < BURST_END;
      s1_op_d    = OP_LINE_READ;
      s1_way_d   = burst_way_q;
      s1_meta_d  = 1'b0;
      s1_last_d  = burst_cnt_q[WORD_W-1:0] == LAST_WORD;
    end
    // Sampled before this cycle's WRITE lands, so WRITE responses merge new metadata later.
    s1_vvec_d = valid_mem[rd_index];
    s1_dvec_d = dirty_mem[rd_index];
  end

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    burst_index_d = burst_index_q;
    burst_way_d   = burst_way_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + INDEX_W'(1);
        if (init_cnt_q == LAST_SET) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept && (req_op == OP_LINE_READ)) begin
          state_d       = ST_BURST;
          burst_cnt_d   = (WORD_W + 1)'(1);
          burst_index_d = req_index_i;
          burst_way_d   = req_way_i;
        end
      end
      ST_BURST: begin
        if (burst_cnt_q < BURST_END) burst_cnt_d = burst_cnt_q + (WORD_W + 1)'(1);
        // Leave only once our own final beat is on the output, not a leftover single beat.
        if ((burst_cnt_q == BURST_END) && !s1_valid_q && rsp_valid_q && rsp_last_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [DATA_W-1:0] data_mem [SETS*WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] rd_dout;
    logic [TAG_W-1:0]  rd_tout;

    always_ff @(posedge clk) begin
      if (data_we && (req_way_i == WAY_W'(gi))) begin
        for (int b = 0; b < BE_W; b++) begin
          if (req_be_i[b]) data_mem[{req_index_i, req_word_i}][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
        end
      end
      if (meta_we && (req_way_i == WAY_W'(gi))) tag_mem[req_index_i] <= req_tag_i;
      rd_dout <= data_mem[{rd_index, rd_word}];
      rd_tout <= tag_mem[rd_index];
    end

    assign rd_data_flat[gi*DATA_W +: DATA_W] = rd_dout;
    assign rd_tag_flat[gi*TAG_W +: TAG_W]    = rd_tout;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      valid_mem[init_cnt_q] <= '0;
      dirty_mem[init_cnt_q] <= '0;
    end else if (meta_we) begin
      valid_mem[req_index_i][req_way_i] <= req_valid_bit_i;
      dirty_mem[req_index_i][req_way_i] <= req_dirty_bit_i;
    end
  end

  logic             lk_hit, lk_multi;
  logic [WAY_W-1:0] lk_way, sel_way;
  logic [DATA_W-1:0] sel_data, be_mask;
  logic [TAG_W-1:0]  sel_tag;

  l2_tag_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W)
  ) u_tag_match (
    .valid_i     (s1_vvec_q),
    .tags_i      (rd_tag_flat),
    .tag_i       (s1_tag_q),
    .hit_o       (lk_hit),
    .multi_hit_o (lk_multi),
    .way_o       (lk_way)
  );

  always_comb begin
    sel_way  = (s1_op_q == OP_LOOKUP) ? lk_way : s1_way_q;
    sel_data = rd_data_flat[sel_way*DATA_W +: DATA_W];
    sel_tag  = rd_tag_flat[sel_way*TAG_W +: TAG_W];
    for (int b = 0; b < BE_W; b++) be_mask[b*8 +: 8] = {8{s1_be_q[b]}};
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_tag_d   = '0;
    rsp_vld_d   = 1'b0;
    rsp_dirty_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_multi_d = 1'b0;
    rsp_way_d   = '0;
    rsp_last_d  = 1'b0;
    if (s1_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_last_d  = s1_last_q;
      case (s1_op_q)
        OP_WRITE: begin
          rsp_data_d  = (sel_data & ~be_mask) | (s1_wdata_q & be_mask);
          rsp_tag_d   = s1_meta_q ? s1_tag_q : sel_tag;
          rsp_vld_d   = s1_meta_q ? s1_vbit_q : s1_vvec_q[sel_way];
          rsp_dirty_d = s1_meta_q ? s1_dbit_q : s1_dvec_q[sel_way];
          rsp_way_d   = s1_way_q;
        end
        OP_LOOKUP: begin
          if (lk_hit) begin
            rsp_data_d  = sel_data;
            rsp_tag_d   = sel_tag;
            rsp_vld_d   = 1'b1;
            rsp_dirty_d = s1_dvec_q[sel_way];
            rsp_hit_d   = 1'b1;
            rsp_multi_d = lk_multi;
            rsp_way_d   = lk_way;
          end
        end
        default: begin
          rsp_data_d  = sel_data;
          rsp_tag_d   = sel_tag;
          rsp_vld_d   = s1_vvec_q[sel_way];
          rsp_dirty_d = s1_dvec_q[sel_way];
          rsp_way_d   = s1_way_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      burst_index_q <= '0;
      burst_way_q   <= '0;
      s1_valid_q    <= 1'b0;
      s1_op_q       <= OP_READ;
      s1_way_q      <= '0;
      s1_be_q       <= '0;
      s1_wdata_q    <= '0;
      s1_tag_q      <= '0;
      s1_meta_q     <= 1'b0;
      s1_vbit_q     <= 1'b0;
      s1_dbit_q     <= 1'b0;
      s1_vvec_q     <= '0;
      s1_dvec_q     <= '0;
      s1_last_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_vld_q     <= 1'b0;
      rsp_dirty_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_multi_q   <= 1'b0;
      rsp_way_q     <= '0;
      rsp_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      burst_index_q <= burst_index_d;
      burst_way_q   <= burst_way_d;
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s1_way_q      <= s1_way_d;
      s1_be_q       <= s1_be_d;
      s1_wdata_q    <= s1_wdata_d;
      s1_tag_q      <= s1_tag_d;
      s1_meta_q     <= s1_meta_d;
      s1_vbit_q     <= s1_vbit_d;
      s1_dbit_q     <= s1_dbit_d;
      s1_vvec_q     <= s1_vvec_d;
      s1_dvec_q     <= s1_dvec_d;
      s1_last_q     <= s1_last_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_dirty_q   <= rsp_dirty_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_multi_q   <= rsp_multi_d;
      rsp_way_q     <= rsp_way_d;
      rsp_last_q    <= rsp_last_d;
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign init_done_o     = (state_q != ST_INIT);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_tag_o       = rsp_tag_q;
  assign rsp_vld_o       = rsp_vld_q;
  assign rsp_dirty_o     = rsp_dirty_q;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_multi_hit_o = rsp_multi_q;
  assign rsp_way_o       = rsp_way_q;
  assign rsp_last_o      = rsp_last_q;

endmodule

// File: tb/tb_l2_array_pipe.sv
// Directed bench for l2_array_pipe: reset sweep, READ/WRITE/LOOKUP, LINE_READ burst,
// back-to-back traffic and reset during a burst.
module tb_l2_array_pipe;
  import l2_arrays_pkg::*;

  localparam int INDEX_W = 8;
  localparam int WAY_W   = 4;
  localparam int WORD_W  = 3;
  localparam int DATA_W  = 64;
  localparam int TAG_W   = 50;
  localparam int BE_W    = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  logic [1:0]         req_op_i = '0;
  logic [INDEX_W-1:0] req_index_i = '0;
  logic [WAY_W-1:0]   req_way_i = '0;
  logic [WORD_W-1:0]  req_word_i = '0;
  logic [BE_W-1:0]    req_be_i = '0;
  logic [DATA_W-1:0]  req_wdata_i = '0;
  logic [TAG_W-1:0]   req_tag_i = '0;
  logic               req_meta_we_i = 1'b0;
  logic               req_valid_bit_i = 1'b0;
  logic               req_dirty_bit_i = 1'b0;
  logic               rsp_valid_o;
  logic [DATA_W-1:0]  rsp_data_o;
  logic [TAG_W-1:0]   rsp_tag_o;
  logic               rsp_vld_o;
  logic               rsp_dirty_o;
  logic               rsp_hit_o;
  logic               rsp_multi_hit_o;
  logic [WAY_W-1:0]   rsp_way_o;
  logic               rsp_last_o;
  logic               init_done_o;

  int checks = 0;
  int errors = 0;

  localparam logic [TAG_W-1:0] TAG_A = 50'h123456789ABC;
  localparam logic [TAG_W-1:0] TAG_B = 50'h0BEEF;

  always #5 clk = ~clk;

  l2_array_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_op_i        (req_op_i),
    .req_index_i     (req_index_i),
    .req_way_i       (req_way_i),
    .req_word_i      (req_word_i),
    .req_be_i        (req_be_i),
    .req_wdata_i     (req_wdata_i),
    .req_tag_i       (req_tag_i),
    .req_meta_we_i   (req_meta_we_i),
    .req_valid_bit_i (req_valid_bit_i),
    .req_dirty_bit_i (req_dirty_bit_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_tag_o       (rsp_tag_o),
    .rsp_vld_o       (rsp_vld_o),
    .rsp_dirty_o     (rsp_dirty_o),
    .rsp_hit_o       (rsp_hit_o),
    .rsp_multi_hit_o (rsp_multi_hit_o),
    .rsp_way_o       (rsp_way_o),
    .rsp_last_o      (rsp_last_o),
    .init_done_o     (init_done_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] idx, input logic [3:0] way,
                       input logic [2:0] word, input logic [7:0] be, input logic [63:0] wd,
                       input logic [49:0] tag, input logic mw, input logic v, input logic d);
    req_valid_i     = 1'b1;
    req_op_i        = op;
    req_index_i     = idx;
    req_way_i       = way;
    req_word_i      = word;
    req_be_i        = be;
    req_wdata_i     = wd;
    req_tag_i       = tag;
    req_meta_we_i   = mw;
    req_valid_bit_i = v;
    req_dirty_bit_i = d;
    $display("req op=%0d index=0x%0h way=%0d word=%0d be=0x%0h wdata=0x%0h tag=0x%0h meta=%0d/%0d/%0d",
             op, idx, way, word, be, wd, tag, mw, v, d);
  endtask

  // Accept on the next edge, then drop the request.
  task automatic issue(input logic [1:0] op, input logic [7:0] idx, input logic [3:0] way,
                       input logic [2:0] word, input logic [7:0] be, input logic [63:0] wd,
                       input logic [49:0] tag, input logic mw, input logic v, input logic d);
    drive(op, idx, way, word, be, wd, tag, mw, v, d);
    step();
    req_valid_i = 1'b0;
  endtask

  // Accept, then advance to the cycle holding the single response beat.
  task automatic single(input logic [1:0] op, input logic [7:0] idx, input logic [3:0] way,
                        input logic [2:0] word, input logic [7:0] be, input logic [63:0] wd,
                        input logic [49:0] tag, input logic mw, input logic v, input logic d);
    issue(op, idx, way, word, be, wd, tag, mw, v, d);
    step();
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!req_ready_o && n < 1000) begin
      step();
      n++;
    end
    chk({tag, "_cycles"}, 64'(n), 64'd256);
    chk({tag, "_done"}, 64'(init_done_o), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_init_done", 64'(init_done_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_data", rsp_data_o, 64'd0);
    chk("rst_rsp_last", 64'(rsp_last_o), 64'd0);
    rst_n = 1'b1;
    wait_init("init1");

    single(OP_LOOKUP, 8'h10, 4'd0, 3'd2, 8'h00, 64'd0, TAG_A, 1'b0, 1'b0, 1'b0);
    chk("lk_empty_valid", 64'(rsp_valid_o), 64'd1);
    chk("lk_empty_hit", 64'(rsp_hit_o), 64'd0);
    chk("lk_empty_data", rsp_data_o, 64'd0);
    chk("lk_empty_last", 64'(rsp_last_o), 64'd1);

    single(OP_WRITE, 8'h10, 4'd5, 3'd2, 8'hFF, 64'hDEADBEEFCAFEBABE, TAG_A, 1'b1, 1'b1, 1'b0);
    chk("wr1_data", rsp_data_o, 64'hDEADBEEFCAFEBABE);
    chk("wr1_vld", 64'(rsp_vld_o), 64'd1);
    chk("wr1_way", 64'(rsp_way_o), 64'd5);

    single(OP_READ, 8'h10, 4'd5, 3'd2, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    chk("rd1_data", rsp_data_o, 64'hDEADBEEFCAFEBABE);
    chk("rd1_tag", 64'(rsp_tag_o), 64'(TAG_A));
    chk("rd1_vld", 64'(rsp_vld_o), 64'd1);
    chk("rd1_dirty", 64'(rsp_dirty_o), 64'd0);
    chk("rd1_hit", 64'(rsp_hit_o), 64'd0);
    chk("rd1_last", 64'(rsp_last_o), 64'd1);

    single(OP_WRITE, 8'h10, 4'd5, 3'd2, 8'h0F, 64'h11111111, '0, 1'b0, 1'b0, 1'b0);
    chk("wr2_data", rsp_data_o, 64'hDEADBEEF11111111);
    chk("wr2_tag", 64'(rsp_tag_o), 64'(TAG_A));

    single(OP_READ, 8'h10, 4'd5, 3'd2, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    chk("rd2_data", rsp_data_o, 64'hDEADBEEF11111111);

    single(OP_LOOKUP, 8'h10, 4'd0, 3'd2, 8'h00, 64'd0, TAG_A, 1'b0, 1'b0, 1'b0);
    chk("lk1_hit", 64'(rsp_hit_o), 64'd1);
    chk("lk1_way", 64'(rsp_way_o), 64'd5);
    chk("lk1_multi", 64'(rsp_multi_hit_o), 64'd0);
    chk("lk1_data", rsp_data_o, 64'hDEADBEEF11111111);

    single(OP_WRITE, 8'h10, 4'd9, 3'd2, 8'hFF, 64'hAAAA, TAG_A, 1'b1, 1'b1, 1'b0);
    chk("wr9_vld", 64'(rsp_vld_o), 64'd1);

    single(OP_WRITE, 8'h10, 4'd5, 3'd2, 8'h00, 64'hFFFFFFFFFFFFFFFF, TAG_A, 1'b1, 1'b1, 1'b1);
    chk("be0_data", rsp_data_o, 64'hDEADBEEF11111111);
    chk("be0_dirty", 64'(rsp_dirty_o), 64'd1);

    single(OP_LOOKUP, 8'h10, 4'd0, 3'd2, 8'h00, 64'd0, TAG_A, 1'b0, 1'b0, 1'b0);
    chk("lk2_hit", 64'(rsp_hit_o), 64'd1);
    chk("lk2_way", 64'(rsp_way_o), 64'd5);
    chk("lk2_multi", 64'(rsp_multi_hit_o), 64'd1);
    chk("lk2_dirty", 64'(rsp_dirty_o), 64'd1);

    single(OP_LOOKUP, 8'h11, 4'd0, 3'd2, 8'h00, 64'd0, TAG_A, 1'b0, 1'b0, 1'b0);
    chk("lk3_hit", 64'(rsp_hit_o), 64'd0);
    chk("lk3_tag", 64'(rsp_tag_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      single(OP_WRITE, 8'h20, 4'd3, 3'(i), 8'hFF, 64'h100 + 64'(i), TAG_B, (i == 0), 1'b1, 1'b0);
    end

    issue(OP_LINE_READ, 8'h20, 4'd3, 3'd5, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    chk("burst_ready_accept", 64'(req_ready_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("beat%0d_valid", i), 64'(rsp_valid_o), 64'd1);
      chk($sformatf("beat%0d_data", i), rsp_data_o, 64'h100 + 64'(i));
      chk($sformatf("beat%0d_last", i), 64'(rsp_last_o), 64'(i == 7));
      chk($sformatf("beat%0d_ready", i), 64'(req_ready_o), 64'd0);
    end
    step();
    chk("burst_end_ready", 64'(req_ready_o), 64'd1);
    chk("burst_end_valid", 64'(rsp_valid_o), 64'd0);

    drive(OP_READ, 8'h20, 4'd3, 3'd1, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    step();
    drive(OP_WRITE, 8'h20, 4'd3, 3'd1, 8'hFF, 64'h5555, '0, 1'b0, 1'b0, 1'b0);
    step();
    chk("b2b_rd_valid", 64'(rsp_valid_o), 64'd1);
    chk("b2b_rd_data", rsp_data_o, 64'h101);
    drive(OP_READ, 8'h20, 4'd3, 3'd1, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    step();
    req_valid_i = 1'b0;
    chk("b2b_wr_valid", 64'(rsp_valid_o), 64'd1);
    chk("b2b_wr_data", rsp_data_o, 64'h5555);
    step();
    chk("b2b_rd2_valid", 64'(rsp_valid_o), 64'd1);
    chk("b2b_rd2_data", rsp_data_o, 64'h5555);

    issue(OP_LINE_READ, 8'h20, 4'd3, 3'd0, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    chk("mid_beat4_data", rsp_data_o, 64'h103);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("mid_rst_ready", 64'(req_ready_o), 64'd0);
    chk("mid_rst_done", 64'(init_done_o), 64'd0);
    chk("mid_rst_data", rsp_data_o, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    wait_init("init2");

    single(OP_LOOKUP, 8'h10, 4'd0, 3'd2, 8'h00, 64'd0, TAG_A, 1'b0, 1'b0, 1'b0);
    chk("post_lk_hit", 64'(rsp_hit_o), 64'd0);
    single(OP_READ, 8'h10, 4'd5, 3'd2, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_rd_vld", 64'(rsp_vld_o), 64'd0);
    chk("post_rd_dirty", 64'(rsp_dirty_o), 64'd0);
    single(OP_READ, 8'h20, 4'd3, 3'd0, 8'h00, 64'd0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_rd20_vld", 64'(rsp_vld_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
